vic_n: RTL and testbench
========================

Name: vic_n

Overview:
Parametrised vectored interrupt controller for the LaRVa SoC, replacing the fixed 5-entry inline VIC in the system top.
- Supports NIRQ sources, each selectable as level- or edge-triggered, with a programmable enable, a programmable vector, and a software-clearable pending bit.
- Fixed priority: trap first, then the lowest source index.
- Drives the CPU irq/ivector inputs and sits on the IO bus like the other memory-mapped peripherals.

Parameters:
- NIRQ, 8, number of interrupt sources (1..16).
- VRST, 30'h0, reset value of every vector register and of TRAPVEC (word address, bits 31:2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cs  in  1  chip select (decoded IO window)
- addr  in  5  word index within window (bus address bits 6:2)
- wdata  in  32  write data
- wstrb  in  4  byte write strobes; 4'b0000 = read
- rdata  out  32  read data (combinational from addr)
- irq_src  in  NIRQ  raw source requests, synchronous to clk
- trap  in  1  CPU trap request
- irq  out  1  interrupt request to CPU
- ivector  out  30  vector word address to CPU

Behaviour:
- Register map (word index):
  - 0 IRQEN[NIRQ-1:0], RW.
  - 1 PEND, RO view of the pending vector.
  - 1 write: W1C of edge-pending bits.
  - 2 MODE[NIRQ-1:0], RW; 1 = edge, 0 = level.
  - 3 STATUS, RO: {valid, 26'b0, vecn[4:0]} of the current registered selection.
  - 4 TRAPVEC, RW [31:2].
  - 16+i VECT[i], RW [31:2] for i < NIRQ.
  - Unmapped reads return 0; unmapped writes are ignored.
- Writes: IRQEN, MODE and W1C need wstrb[0], and use bits up to NIRQ-1. Vector and TRAPVEC writes need wstrb == 4'b1111; partial writes are ignored.
- Edge detect: register src_q <= irq_src. rise = irq_src & ~src_q.
- Edge latch: an edge-mode source sets edge_pend[i] on rise. A W1C bit clears it. If a set and a clear hit the same cycle, the set wins.
- Level-mode sources have no latch: raw[i] = irq_src[i].
- raw[i] = MODE[i] ? edge_pend[i] : irq_src[i]. PEND = raw, reported regardless of enable.
- Masking: act = raw & IRQEN.
- Priority encoder selects the lowest set index of act and gives {valid, idx}.
- Registered stage:
  - irq_q <= valid; vecn_q <= idx; vec_q <= VECT[idx].
  - A source is therefore visible on irq exactly 1 cycle after act asserts.
  - Deassertion also takes 1 cycle.
- Outputs:
  - irq = irq_q | trap.
  - ivector = trap ? TRAPVEC : (irq_q ? vec_q : TRAPVEC).
  - trap path is combinational, 0 cycle.
- Changing MODE from edge to level does not clear edge_pend. edge_pend is only used when MODE = 1.
- Disabling a source (IRQEN bit = 0) removes it from selection on the next registered update. Its edge_pend is kept.
- Reset state:
  - IRQEN, MODE, edge_pend, src_q, irq_q = 0; vecn_q = 0.
  - vec_q, every VECT and TRAPVEC = VRST.
  - irq = trap; ivector = VRST.
  - Reset asserted mid-operation discards all pending state in that cycle.
  - A source held high through reset is not counted as an edge: src_q is loaded from irq_src on the first cycle after reset.
- A bus write to VECT[idx] in the same cycle the selection is registered: vec_q takes the old value. The new value is used from the next cycle.

Decomposition:
- Package vic_pkg: register index constants (IDX_IRQEN=0, IDX_PEND=1, IDX_MODE=2, IDX_STATUS=3, IDX_TRAPVEC=4, IDX_VECT0=16) and MAX_NIRQ=16.
- One sub-module, vic_prio_enc (parameter N):
  - input act[N-1:0]; outputs valid and idx[4:0].
  - Purely combinational, lowest index wins.

Test Plan:
- Reset, then read all registers: IRQEN/MODE/PEND = 0, VECT[3] = VRST; irq = 0; ivector = VRST.
- Level source: VECT[2] = 0x100 (word 0x40), IRQEN = 0x04, hold irq_src[2] = 1. irq rises 1 cycle later and ivector = 0x40. Drop the source: irq falls 1 cycle later.
- Edge source: MODE[5] = 1, IRQEN[5] = 1, 1-cycle pulse on irq_src[5]. PEND[5] = 1 and irq stays high. Write PEND = 0x20: irq falls 1 cycle later. A new pulse in the same cycle as the W1C leaves PEND[5] = 1.
- Priority: sources 1 and 6 active with VECT[1] = 0x200 and VECT[6] = 0x600. ivector = 0x200>>2. Clear source 1: ivector = 0x600>>2 the next cycle. STATUS reads 0x80000006.
- Trap: while source 3 is asserting irq, assert trap. irq stays 1 and ivector = TRAPVEC in the same cycle. Deasserting trap restores VECT[3].
- Masking and partial writes: IRQEN = 0 with a source active gives irq = 0 and PEND bit = 1. A write to VECT[0] with wstrb = 4'b0011 leaves VECT[0] unchanged.

Source files
------------

// File: rtl/vic_pkg.sv
// Shared constants for the vectored interrupt controller: register word
// indices within the IO window and the source-count ceiling.
package vic_pkg;

    localparam int MAX_NIRQ = 16;

    localparam logic [4:0] IDX_IRQEN   = 5'd0;
    localparam logic [4:0] IDX_PEND    = 5'd1;
    localparam logic [4:0] IDX_MODE    = 5'd2;
    localparam logic [4:0] IDX_STATUS  = 5'd3;
    localparam logic [4:0] IDX_TRAPVEC = 5'd4;
    localparam logic [4:0] IDX_VECT0   = 5'd16;

endpackage

// File: rtl/vic_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set bit of act wins.
module vic_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] act,
    output logic         valid,
    output logic [4:0]   idx
);

    always_comb begin
        idx = '0;
        // Walk downwards so the lowest set index is the last one assigned.
        for (int i = N - 1; i >= 0; i--) begin
            if (act[i]) idx = 5'(i);
        end
        valid = |act;
    end

endmodule

// File: rtl/vic_n.sv
// Parametrised vectored interrupt controller: per-source level/edge mode,
// enable, vector and W1C pending, with a registered selection and trap bypass.
module vic_n
    import vic_pkg::*;
#(
    parameter int          NIRQ = 8,
    parameter logic [29:0] VRST = 30'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cs,
    input  logic [4:0]      addr,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    output logic [31:0]     rdata,
    input  logic [NIRQ-1:0] irq_src,
    input  logic            trap,
    output logic            irq,
    output logic [29:0]     ivector
);

    logic [NIRQ-1:0] irqen;
    logic [NIRQ-1:0] mode;
    logic [NIRQ-1:0] edge_pend;
    logic [NIRQ-1:0] src_q;
    logic            armed;
    logic            irq_q;
    logic [4:0]      vecn_q;
    logic [29:0]     vec_q;
    logic [29:0]     trapvec;
    logic [29:0]     vect [NIRQ];

    logic            wr_lo;
    logic            wr_full;
    logic            vect_hit;
    logic [NIRQ-1:0] w1c;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] raw;
    logic [NIRQ-1:0] act;
    logic            sel_valid;
    logic [4:0]      sel_idx;
    logic [29:0]     sel_vec;
    logic [29:0]     rd_vec;

    assign wr_lo    = cs && wstrb[0];
    assign wr_full  = cs && (wstrb == 4'b1111);
    assign vect_hit = addr[4] && (int'(addr[3:0]) < NIRQ);
    assign w1c      = (wr_lo && addr == IDX_PEND) ? wdata[NIRQ-1:0] : '0;

    // armed stays low for the first cycle after reset so a source held high
    // through reset is not mistaken for a fresh edge.
    assign rise = irq_src & ~src_q & {NIRQ{armed}};
    assign raw  = (mode & edge_pend) | (~mode & irq_src);
    assign act  = raw & irqen;

    vic_prio_enc #(.N(NIRQ)) u_prio (
        .act   (act),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_comb begin
        sel_vec = vect[0];
        rd_vec  = vect[0];
        for (int i = 0; i < NIRQ; i++) begin
            if (sel_idx == 5'(i))   sel_vec = vect[i];
            if (addr[3:0] == 4'(i)) rd_vec  = vect[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqen     <= '0;
            mode      <= '0;
            edge_pend <= '0;
            src_q     <= '0;
            armed     <= 1'b0;
            irq_q     <= 1'b0;
            vecn_q    <= '0;
            vec_q     <= VRST;
            trapvec   <= VRST;
            for (int i = 0; i < NIRQ; i++) vect[i] <= VRST;
        end else begin
            src_q     <= irq_src;
            armed     <= 1'b1;
            edge_pend <= (edge_pend & ~w1c) | (rise & mode);
            irq_q     <= sel_valid;
            vecn_q    <= sel_idx;
            vec_q     <= sel_vec;
            if (wr_lo && addr == IDX_IRQEN) irqen <= wdata[NIRQ-1:0];
            if (wr_lo && addr == IDX_MODE)  mode  <= wdata[NIRQ-1:0];
            if (wr_full && addr == IDX_TRAPVEC) trapvec <= wdata[31:2];
            if (wr_full && vect_hit) begin
                for (int i = 0; i < NIRQ; i++) begin
                    if (addr[3:0] == 4'(i)) vect[i] <= wdata[31:2];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            IDX_IRQEN:   rdata[NIRQ-1:0] = irqen;
            IDX_PEND:    rdata[NIRQ-1:0] = raw;
            IDX_MODE:    rdata[NIRQ-1:0] = mode;
            IDX_STATUS:  rdata = {irq_q, 26'b0, vecn_q};
            IDX_TRAPVEC: rdata = {trapvec, 2'b00};
            default:     if (vect_hit) rdata = {rd_vec, 2'b00};
        endcase
    end

    assign irq     = irq_q | trap;
    assign ivector = (trap || !irq_q) ? trapvec : vec_q;

endmodule

// File: tb/tb_vic_n.sv
// Directed bench for vic_n: bus access, level/edge sources, priority, trap,
// masking, partial writes and mid-operation reset.
module tb_vic_n;

    localparam int          NIRQ  = 8;
    localparam logic [29:0] VRST  = 30'h0000_1234;
    localparam logic [31:0] VRSTB = {VRST, 2'b00};

    logic            clk = 1'b0;
    logic            reset;
    logic            cs;
    logic [4:0]      addr;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic [31:0]     rdata;
    logic [NIRQ-1:0] irq_src;
    logic            trap;
    logic            irq;
    logic [29:0]     ivector;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] rd;

    vic_n #(.NIRQ(NIRQ), .VRST(VRST)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .addr    (addr),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .rdata   (rdata),
        .irq_src (irq_src),
        .trap    (trap),
        .irq     (irq),
        .ivector (ivector)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        cs = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        cs = 1'b0; wstrb = 4'b0000;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        #1 d = rdata;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        irq_src = '0; trap = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        #1;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ivec", 32'(ivector), 32'(VRST));
        bus_rd(5'd0, rd);  chk("rst_irqen", rd, 32'h0);
        bus_rd(5'd1, rd);  chk("rst_pend", rd, 32'h0);
        bus_rd(5'd2, rd);  chk("rst_mode", rd, 32'h0);
        bus_rd(5'd3, rd);  chk("rst_status", rd, 32'h0);
        bus_rd(5'd4, rd);  chk("rst_trapvec", rd, VRSTB);
        bus_rd(5'd19, rd); chk("rst_vect3", rd, VRSTB);

        // level source 2
        bus_wr(5'd18, 32'h100, 4'b1111);
        bus_wr(5'd0, 32'h04, 4'b0001);
        @(negedge clk); irq_src[2] = 1'b1;
        #1 chk("lvl_irq_lat0", 32'(irq), 32'd0);
        step();
        chk("lvl_irq", 32'(irq), 32'd1);
        chk("lvl_ivec", 32'(ivector), 32'h40);
        bus_rd(5'd1, rd); chk("lvl_pend", rd, 32'h04);
        @(negedge clk); irq_src[2] = 1'b0;
        #1 chk("lvl_fall_lat0", 32'(irq), 32'd1);
        step();
        chk("lvl_fall", 32'(irq), 32'd0);

        // edge source 5
        bus_wr(5'd2, 32'h20, 4'b0001);
        bus_wr(5'd0, 32'h20, 4'b0001);
        @(negedge clk); irq_src[5] = 1'b1;
        @(negedge clk); irq_src[5] = 1'b0;
        bus_rd(5'd1, rd); chk("edge_pend", rd, 32'h20);
        chk("edge_irq", 32'(irq), 32'd1);
        chk("edge_ivec", 32'(ivector), 32'(VRST));
        step();
        chk("edge_irq_hold", 32'(irq), 32'd1);
        bus_wr(5'd1, 32'h20, 4'b0001);
        #1 chk("w1c_lat0", 32'(irq), 32'd1);
        step();
        chk("w1c_irq", 32'(irq), 32'd0);
        bus_rd(5'd1, rd); chk("w1c_pend", rd, 32'h0);
        // set and clear in the same cycle: set wins
        @(negedge clk);
        irq_src[5] = 1'b1; cs = 1'b1; addr = 5'd1; wdata = 32'h20; wstrb = 4'b0001;
        @(negedge clk);
        irq_src[5] = 1'b0; cs = 1'b0; wstrb = 4'b0000;
        bus_rd(5'd1, rd); chk("w1c_vs_set", rd, 32'h20);
        bus_wr(5'd0, 32'h00, 4'b0001);
        bus_wr(5'd1, 32'h20, 4'b0001);
        step();
        chk("edge_clean_irq", 32'(irq), 32'd0);

        // priority between sources 1 and 6
        bus_wr(5'd17, 32'h200, 4'b1111);
        bus_wr(5'd22, 32'h600, 4'b1111);
        bus_wr(5'd0, 32'h42, 4'b0001);
        @(negedge clk); irq_src[1] = 1'b1; irq_src[6] = 1'b1;
        step();
        chk("prio_irq", 32'(irq), 32'd1);
        chk("prio_ivec1", 32'(ivector), 32'h80);
        bus_rd(5'd3, rd); chk("prio_status1", rd, 32'h8000_0001);
        @(negedge clk); irq_src[1] = 1'b0;
        #1 chk("prio_ivec_lat0", 32'(ivector), 32'h80);
        step();
        chk("prio_ivec6", 32'(ivector), 32'h180);
        bus_rd(5'd3, rd); chk("prio_status6", rd, 32'h8000_0006);
        @(negedge clk); irq_src[6] = 1'b0;

        // trap overrides source 3
        bus_wr(5'd19, 32'h300, 4'b1111);
        bus_wr(5'd4, 32'hF00, 4'b1111);
        bus_wr(5'd0, 32'h08, 4'b0001);
        @(negedge clk); irq_src[3] = 1'b1;
        step();
        chk("trap_pre_ivec", 32'(ivector), 32'hC0);
        @(negedge clk); trap = 1'b1;
        #1 chk("trap_irq", 32'(irq), 32'd1);
        chk("trap_ivec", 32'(ivector), 32'h3C0);
        @(negedge clk); trap = 1'b0;
        #1 chk("trap_restore", 32'(ivector), 32'hC0);

        // masking
        bus_wr(5'd0, 32'h00, 4'b0001);
        #1 chk("mask_lat0", 32'(irq), 32'd1);
        step();
        chk("mask_irq", 32'(irq), 32'd0);
        chk("mask_ivec", 32'(ivector), 32'h3C0);
        bus_rd(5'd1, rd); chk("mask_pend", rd, 32'h08);

        // partial / unmapped accesses
        bus_wr(5'd16, 32'hDEAD_BEEC, 4'b0011);
        bus_rd(5'd16, rd); chk("partial_vect0", rd, VRSTB);
        bus_wr(5'd4, 32'h1234_5678, 4'b0111);
        bus_rd(5'd4, rd); chk("partial_trapvec", rd, 32'hF00);
        bus_wr(5'd5, 32'hFFFF_FFFF, 4'b1111);
        bus_rd(5'd5, rd); chk("unmapped5", rd, 32'h0);
        bus_wr(5'd25, 32'hFFFF_FFFC, 4'b1111);
        bus_rd(5'd25, rd); chk("vect_oob", rd, 32'h0);

        // trap alone
        @(negedge clk); trap = 1'b1;
        #1 chk("trap_only_irq", 32'(irq), 32'd1);
        chk("trap_only_ivec", 32'(ivector), 32'h3C0);
        @(negedge clk); trap = 1'b0;
        #1 chk("trap_only_off", 32'(irq), 32'd0);

        // reset mid-operation
        bus_wr(5'd0, 32'h08, 4'b0001);
        step();
        chk("prerst_irq", 32'(irq), 32'd1);
        @(negedge clk); reset = 1'b1;
        step();
        chk("midrst_irq", 32'(irq), 32'd0);
        chk("midrst_ivec", 32'(ivector), 32'(VRST));
        @(negedge clk); reset = 1'b0;
        bus_rd(5'd0, rd);  chk("midrst_irqen", rd, 32'h0);
        bus_rd(5'd19, rd); chk("midrst_vect3", rd, VRSTB);
        irq_src = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
